heart_move_ctrl: RTL

Converts the four raw player buttons into movement commands for the heart sprite during the dodge phase. It sits directly upstream of the heart sprite stage and drives that stage's 3-bit `state` input. The sprite stage moves the heart 5 px on every `Pclk` cycle in which `state` holds a direction code, so this block emits each command as a single-cycle pulse. Pulses are paced to the frame and occur only during vertical blanking.

---
 rtl/heart_move_ctrl_if.sv | 23 ++
 rtl/heart_move_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/heart_move_ctrl_if.sv
// Button, frame-position and movement-command signals between the
// game logic (master) and the heart movement controller (slave).
interface heart_move_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       move_en;
  logic [9:0] xx;
  logic [9:0] yy;
  logic [2:0] state;
  logic [7:0] move_cnt;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, move_en, xx, yy,
    input  state, move_cnt
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, move_en, xx, yy,
    output state, move_cnt
  );
endinterface

// File: rtl/heart_move_ctrl.sv
// Heart movement controller: debounces the four buttons and emits one-cycle
// direction pulses to the sprite stage, paced to the start of vertical blanking.
module heart_move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STEP_FRAMES     = 2
) (
  input logic              Pclk,
  input logic              rst_n,
  heart_move_ctrl_if.slave io
);
  localparam int          NUM_BTN   = 4;
  localparam logic [19:0] DB_LAST   = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]  STEP_LAST = 4'(STEP_FRAMES - 1);

  localparam logic [2:0] CMD_UP    = 3'b000;
  localparam logic [2:0] CMD_DOWN  = 3'b001;
  localparam logic [2:0] CMD_LEFT  = 3'b010;
  localparam logic [2:0] CMD_RIGHT = 3'b011;
  localparam logic [2:0] CMD_IDLE  = 3'b111;

  typedef enum logic [1:0] {IDLE, FIRST, REPEAT} fsm_t;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_deb;
  logic               frame_tick;
  logic [3:0]         frame_cnt;
  fsm_t               fsm;
  logic               dir_vld;
  logic [2:0]         dir_code;
  logic               issue;

  // bit order: 0 up, 1 down, 2 left, 3 right
  assign btn_raw = {io.btn_right, io.btn_left, io.btn_down, io.btn_up};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    logic [1:0]  sync;
    logic [19:0] cnt;
    logic        level;

    always_ff @(posedge Pclk or negedge rst_n) begin
      if (!rst_n) begin
        sync  <= '0;
        cnt   <= '0;
        level <= 1'b0;
      end else begin
        sync <= {sync[0], btn_raw[i]};
        if (sync[1] == level) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          cnt   <= '0;
          level <= ~level;
        end else begin
          cnt <= cnt + 20'd1;
        end
      end
    end

    assign btn_deb[i] = level;
  end

  // one cycle after the first pixel of line 480 = start of vertical blanking
  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) frame_tick <= 1'b0;
    else        frame_tick <= (io.xx == 10'd0) && (io.yy == 10'd480);
  end

  // opposing buttons cancel; vertical wins over horizontal
  always_comb begin
    dir_vld  = 1'b1;
    dir_code = CMD_IDLE;
    if (btn_deb[0] && !btn_deb[1])      dir_code = CMD_UP;
    else if (btn_deb[1] && !btn_deb[0]) dir_code = CMD_DOWN;
    else if (btn_deb[2] && !btn_deb[3]) dir_code = CMD_LEFT;
    else if (btn_deb[3] && !btn_deb[2]) dir_code = CMD_RIGHT;
    else                                dir_vld  = 1'b0;
  end

  always_comb begin
    issue = 1'b0;
    if (io.move_en && frame_tick && dir_vld)
      issue = (fsm == FIRST) || ((fsm == REPEAT) && (frame_cnt == STEP_LAST));
  end

  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= IDLE;
      frame_cnt   <= '0;
      io.state    <= CMD_IDLE;
      io.move_cnt <= '0;
    end else begin
      io.state <= issue ? dir_code : CMD_IDLE;
      if (issue && (io.move_cnt != 8'hFF)) io.move_cnt <= io.move_cnt + 8'd1;

      if (!io.move_en) begin
        fsm       <= IDLE;
        frame_cnt <= '0;
      end else begin
        case (fsm)
          IDLE: if (dir_vld) fsm <= FIRST;
          FIRST: begin
            if (!dir_vld) begin
              fsm <= IDLE;
            end else if (frame_tick) begin
              fsm       <= REPEAT;
              frame_cnt <= '0;
            end
          end
          REPEAT: begin
            if (!dir_vld) begin
              fsm       <= IDLE;
              frame_cnt <= '0;
            end else if (frame_tick) begin
              frame_cnt <= (frame_cnt == STEP_LAST) ? 4'd0 : frame_cnt + 4'd1;
            end
          end
          default: fsm <= IDLE;
        endcase
      end
    end
  end
endmodule
